t07_fpu_div_ctrl: RTL
=====================

Name: t07_fpu_div_ctrl

Overview:
Sequencer and round-robin arbiter that shares one iterative divider between NUM_REQ requesters, such as the integer ALU path and the FPU mantissa path. It accepts one request at a time over valid/ready and latches the operands. It pulses the divider start, waits for done, and returns the quotient and remainder tagged with the requester ID. Divide-by-zero is resolved locally without using the divider.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
WIDTH, 32, operand/result width
TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  clock
nrst  input  1  reset, asynchronous, active-low
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_a  input  NUM_REQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  divisors, same packing
req_signA  input  NUM_REQ  dividend sign bits
req_signB  input  NUM_REQ  divisor sign bits
div_start  output  1  one-cycle launch pulse to the divider
div_a  output  WIDTH  latched dividend to the divider
div_b  output  WIDTH  latched divisor to the divider
div_done  input  1  divider result valid (pulse or level)
div_quot  input  WIDTH  divider quotient
div_rem  input  WIDTH  divider remainder
rsp_valid  output  1  response valid
rsp_ready  input  1  consumer accepts the response
rsp_id  output  $clog2(NUM_REQ)  ID of the requester that is answered
rsp_quot  output  WIDTH  quotient
rsp_rem  output  WIDTH  remainder
rsp_sign  output  1  signA XOR signB of the request
rsp_dz  output  1  divide-by-zero flag
rsp_err  output  1  timeout flag (constant 0 without the optional feature)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset:
  - state goes to IDLE and the round-robin pointer to 0.
  - All outputs are 0, including div_start, req_ready, rsp_valid, busy and all data buses.
  - Reset asserted mid-operation aborts immediately. No response is produced, and a divider result arriving after reset is ignored.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid set, searching from the pointer upward with wrap.
  - req_ready[grant] is driven high combinationally in the same cycle, so the handshake completes in that cycle.
  - The controller latches a, b, signA, signB and the ID, then sets pointer = (grant+1) mod NUM_REQ.
  - If the latched b is 0: go to RESP with rsp_dz=1, rsp_quot = all-ones, rsp_rem = a. div_start is never pulsed.
  - Otherwise: go to LAUNCH.
  - With no req_valid set, stay in IDLE and keep req_ready = 0.
- LAUNCH: div_start=1 for exactly one cycle, then go to WAIT. div_a and div_b hold the latched operands from LAUNCH through the end of WAIT.
- WAIT:
  - On the first cycle with div_done=1, latch div_quot and div_rem and go to RESP.
  - div_done is ignored in every other state.
- RESP:
  - rsp_valid=1, and all rsp_* outputs stay stable until rsp_ready=1.
  - On the handshake cycle, return to IDLE. A new grant is possible on the next cycle at the earliest.
- req_ready stays 0 in all states except IDLE, so a request is never accepted while another is in flight.
- rsp_sign = signA XOR signB for both normal and divide-by-zero responses.
- Latency:
  - Accept at cycle 0, div_start at cycle 1.
  - rsp_valid rises the cycle after div_done is sampled.
  - Divide-by-zero: rsp_valid at cycle 1.
- Simultaneous valid: exactly one requester is granted. Losers keep req_valid asserted and are served later in rotation.

Optional Feature:
T07_DIV_TIMEOUT_EN
- With the macro defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without div_done, go to RESP with rsp_err=1 and quot = rem = 0.
  - A div_done arriving in the same cycle as the timeout wins, giving a normal response with rsp_err=0.
- Without the macro: no counter exists, rsp_err is tied to 0, and WAIT waits indefinitely.

Test Plan:
- Single request: req0 with a=100, b=7, signA=0, signB=1; model done after 33 cycles with quot=14, rem=2 -> div_start at cycle 1; rsp id=0, quot=14, rem=2, sign=1, dz=0.
- Contention: req0 and req1 valid together from reset -> req0 served first, then req1; with both held valid, grants alternate 0,1,0,1.
- Divide-by-zero: req1 with a=0x55, b=0 -> no div_start; rsp_valid at cycle 1 with id=1, quot=0xFFFFFFFF, rem=0x55, dz=1.
- Backpressure: rsp_ready held 0 for 10 cycles -> rsp_* stable, req_ready=0 throughout; accept on release, then IDLE.
- Reset mid-WAIT: deassert nrst during WAIT, release, then pulse div_done -> all outputs 0, no rsp_valid, pointer=0.
- With T07_DIV_TIMEOUT_EN and TIMEOUT_CYCLES=64: div_done never arrives -> rsp_err=1 and rsp_quot = rsp_rem = 0 on the 65th WAIT cycle. Separately, div_done in the same cycle as the timeout -> normal response, err=0.

Source files
------------

// File: rtl/t07_fpu_div_ctrl_if.sv
// Request, divider and response signals of the shared-divider sequencer.
// master: requesters, divider and response consumer; slave: the controller.
// Interface only; no logic and no latency of its own.
interface t07_fpu_div_ctrl_if #(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*WIDTH-1:0] req_a;
   logic [NUM_REQ*WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]       req_signA;
   logic [NUM_REQ-1:0]       req_signB;

   logic                     div_start;
   logic [WIDTH-1:0]         div_a;
   logic [WIDTH-1:0]         div_b;
   logic                     div_done;
   logic [WIDTH-1:0]         div_quot;
   logic [WIDTH-1:0]         div_rem;

   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [WIDTH-1:0]         rsp_quot;
   logic [WIDTH-1:0]         rsp_rem;
   logic                     rsp_sign;
   logic                     rsp_dz;
   logic                     rsp_err;
   logic                     busy;

   modport master (
      output req_valid, req_a, req_b, req_signA, req_signB,
      output div_done, div_quot, div_rem, rsp_ready,
      input  req_ready, div_start, div_a, div_b,
      input  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_sign, rsp_dz, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_signA, req_signB,
      input  div_done, div_quot, div_rem, rsp_ready,
      output req_ready, div_start, div_a, div_b,
      output rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_sign, rsp_dz, rsp_err, busy
   );
endinterface

// File: rtl/t07_fpu_div_ctrl.sv
// Round-robin sequencer sharing one iterative divider between NUM_REQ requesters.
// Latency: accept at 0, div_start at 1, response the cycle after div_done; divide-by-zero responds at 1.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
// Optional watchdog on the divider wait: define T07_DIV_TIMEOUT_EN.
module t07_fpu_div_ctrl #(
   parameter int NUM_REQ        = 2,
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               nrst,
   t07_fpu_div_ctrl_if.slave  bus
);
   localparam int ID_W = $clog2(NUM_REQ);
   localparam int SUM_W = ID_W + 1;

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
      $error("t07_fpu_div_ctrl: unsupported NUM_REQ or TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

   state_t            state;
   logic [ID_W-1:0]   ptr;
   logic [WIDTH-1:0]  a_q, b_q, quot_q, rem_q;
   logic [ID_W-1:0]   id_q;
   logic              sign_q, dz_q, valid_q, start_q, busy_q;

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [SUM_W-1:0]     sum;
   logic                 gnt_vld;
   logic [ID_W-1:0]      gnt_id;
   logic [ID_W-1:0]      ptr_nxt;
   logic [WIDTH-1:0]     sel_a, sel_b;
   logic                 sel_sa, sel_sb;

   // Rotate the valids so bit 0 is the pointer; lowest set offset wins.
   always_comb begin
      dbl     = {bus.req_valid, bus.req_valid} >> ptr;
      rot     = dbl[NUM_REQ-1:0];
      gnt_vld = 1'b0;
      gnt_id  = '0;
      sum     = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
            gnt_vld = 1'b1;
            gnt_id  = sum[ID_W-1:0];
         end
      end
   end

   // Operand mux for the granted requester and the next pointer value.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_sa = 1'b0;
      sel_sb = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == ID_W'(i)) begin
            sel_a  = bus.req_a[i*WIDTH +: WIDTH];
            sel_b  = bus.req_b[i*WIDTH +: WIDTH];
            sel_sa = bus.req_signA[i];
            sel_sb = bus.req_signB[i];
         end
      end
      ptr_nxt = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
   end

   // Handshake completes combinationally in IDLE; held low while in reset.
   assign bus.req_ready = (nrst && state == ST_IDLE && gnt_vld) ? (NUM_REQ'(1) << gnt_id) : '0;

   assign bus.div_start = start_q;
   assign bus.div_a     = a_q;
   assign bus.div_b     = b_q;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_quot  = quot_q;
   assign bus.rsp_rem   = rem_q;
   assign bus.rsp_sign  = sign_q;
   assign bus.rsp_dz    = dz_q;
   assign bus.busy      = busy_q;

`ifdef T07_DIV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
   logic             err_q;
   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   // Sequencer: accept, launch, wait for the divider, hold the response.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         id_q    <= '0;
         sign_q  <= 1'b0;
         dz_q    <= 1'b0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef T07_DIV_TIMEOUT_EN
         cnt     <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_vld) begin
                  a_q    <= sel_a;
                  b_q    <= sel_b;
                  id_q   <= gnt_id;
                  sign_q <= sel_sa ^ sel_sb;
                  ptr    <= ptr_nxt;
                  busy_q <= 1'b1;
`ifdef T07_DIV_TIMEOUT_EN
                  err_q  <= 1'b0;
`endif
                  if (sel_b == '0) begin
                     // Divide-by-zero never touches the divider.
                     dz_q    <= 1'b1;
                     quot_q  <= '1;
                     rem_q   <= sel_a;
                     valid_q <= 1'b1;
                     state   <= ST_RESP;
                  end else begin
                     dz_q    <= 1'b0;
                     start_q <= 1'b1;
                     state   <= ST_LAUNCH;
                  end
               end
            end
            ST_LAUNCH: begin
               start_q <= 1'b0;
`ifdef T07_DIV_TIMEOUT_EN
               cnt     <= '0;
`endif
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.div_done) begin
                  quot_q  <= bus.div_quot;
                  rem_q   <= bus.div_rem;
                  valid_q <= 1'b1;
                  state   <= ST_RESP;
`ifdef T07_DIV_TIMEOUT_EN
               end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  quot_q  <= '0;
                  rem_q   <= '0;
                  err_q   <= 1'b1;
                  valid_q <= 1'b1;
                  state   <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
`endif
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
